// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 serial receiver feeding the UART receive FIFO
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 rcv_full,
    input  logic                 data_ack,
    input  logic                 overrun_clear,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rcv_write,
    output logic                 data_ready,
    output logic                 error_flag,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic                 sync1, s, s_d;
    logic [DIV_WIDTH-1:0] cnt, cnt_next;
    logic [DIV_WIDTH-1:0] div, div_next;
    logic [DIV_WIDTH-1:0] eff_div;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 take, drop, frame_err;

    // Synchronizer and edge-detect flops idle high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            s     <= 1'b1;
            s_d   <= 1'b1;
        end else begin
            sync1 <= serial_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    assign eff_div = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        div_next     = div;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        take         = 1'b0;
        drop         = 1'b0;
        frame_err    = 1'b0;
        case (state)
            IDLE: begin
                if (s_d && !s) begin
                    div_next   = eff_div;
                    cnt_next   = (eff_div >> 1) - DIV_WIDTH'(1);
                    state_next = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!s) begin
                        state_next   = DATA;
                        cnt_next     = div - DIV_WIDTH'(1);
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_next   = {s, shreg[DATA_BITS-1:1]};
                    cnt_next     = div - DIV_WIDTH'(1);
                    bit_idx_next = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt - DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    if (!s) begin
                        frame_err = 1'b1;
                    end else if (rcv_full) begin
                        drop = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - DIV_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            div     <= div_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
        end
    end

    // Set terms take priority over the simultaneous ack/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rcv_write     <= 1'b0;
            error_flag    <= 1'b0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            rcv_write     <= take;
            error_flag    <= frame_err;
            data_ready    <= take | (data_ready & ~data_ack);
            overrun_error <= drop | (overrun_error & ~overrun_clear);
            if (take) begin
                rx_data <= shreg;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx against a sample-point model
module tb_uart_rx;

    localparam int DB   = 8;
    localparam int DW   = 16;
    localparam int MAXC = 100000;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic [DW-1:0] baud_div;
    logic          rcv_full;
    logic          data_ack;
    logic          overrun_clear;
    logic [DB-1:0] rx_data;
    logic          rcv_write, data_ready, error_flag, overrun_error, busy;

    always #5 clk = ~clk;

    uart_rx #(.DATA_BITS(DB), .DIV_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .baud_div      (baud_div),
        .rcv_full      (rcv_full),
        .data_ack      (data_ack),
        .overrun_clear (overrun_clear),
        .rx_data       (rx_data),
        .rcv_write     (rcv_write),
        .data_ready    (data_ready),
        .error_flag    (error_flag),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit line_h [MAXC];

    // Model: frame described by its detection cycle and divisor; sample points from arithmetic.
    bit          m_active;
    int          m_t0, m_div;
    logic [7:0]  m_bits;
    logic [7:0]  e_data;
    bit          e_wr, e_rdy, e_err, e_ovr, e_busy;

    int          wr_cnt, err_cnt, busy_cnt;
    logic [7:0]  wq[$];
    bit          rand_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        bit sv;
        int off, h, k;
        bit nr, no;
        if (rst) begin
            line_h[cyc] = 1'b1;
            chk("reset_outputs", {rx_data, rcv_write, data_ready, error_flag, overrun_error, busy}, 32'd0);
            m_active = 0;
            e_data = '0; e_wr = 0; e_rdy = 0; e_err = 0; e_ovr = 0; e_busy = 0;
        end else begin
            line_h[cyc] = serial_in;
            chk("outputs{data,wr,rdy,err,ovr,busy}",
                {rx_data, rcv_write, data_ready, error_flag, overrun_error, busy},
                {e_data, e_wr, e_rdy, e_err, e_ovr, e_busy});
            if (rcv_write === 1'b1) begin
                wr_cnt++;
                wq.push_back(rx_data);
            end
            if (error_flag === 1'b1) err_cnt++;
            if (busy === 1'b1) busy_cnt++;

            nr = e_rdy && !data_ack;
            no = e_ovr && !overrun_clear;
            e_wr = 0;
            e_err = 0;
            sv = line_h[cyc-2];
            if (!m_active) begin
                if (line_h[cyc-3] && !sv) begin
                    m_active = 1;
                    m_t0 = cyc;
                    m_div = (baud_div < 2) ? 2 : int'(baud_div);
                end
            end else begin
                off = cyc - m_t0;
                h = m_div / 2;
                if (off == h) begin
                    if (sv) m_active = 0;
                end else if (off > h && (off - h) % m_div == 0) begin
                    k = (off - h) / m_div - 1;
                    if (k < DB) begin
                        m_bits[k] = sv;
                    end else begin
                        m_active = 0;
                        if (!sv) e_err = 1;
                        else if (rcv_full) no = 1;
                        else begin
                            e_wr = 1;
                            e_data = m_bits;
                            nr = 1;
                        end
                    end
                end
            end
            e_rdy = nr;
            e_ovr = no;
            e_busy = m_active;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, MAXC);
            $fatal(1);
        end
    endtask

    task automatic idle(input int n, input bit level);
        for (int i = 0; i < n; i++) begin
            serial_in = level;
            data_ack = 1'b0;
            overrun_clear = 1'b0;
            rst = 1'b0;
            step();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stopb, input int bd,
                              input int clr_off, input int rst_off);
        int bl;
        int b;
        bl = (bd < 2) ? 2 : bd;
        baud_div = DW'(bd);
        for (int i = 0; i < 10 * bl; i++) begin
            b = i / bl;
            rst = 1'b0;
            serial_in = (b == 0) ? 1'b0 : (b <= DB) ? d[b-1] : stopb;
            overrun_clear = (i == clr_off);
            data_ack = 1'b0;
            if (rand_en) begin
                data_ack = ($urandom_range(0, 7) == 0);
                if (clr_off < 0) overrun_clear = ($urandom_range(0, 15) == 0);
                if (i == 3) baud_div = DW'($urandom_range(0, 20));
            end
            if (i == rst_off) begin
                #2;
                rst = 1'b1;
                #1;
                chk("async_reset_outputs",
                    {rx_data, rcv_write, data_ready, error_flag, overrun_error, busy}, 32'd0);
            end
            step();
        end
        rst = 1'b0;
        overrun_clear = 1'b0;
        data_ack = 1'b0;
    endtask

    int w0, e0, b0, bl;
    int bds[3] = '{16, 3, 0};

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        baud_div = 16;
        rcv_full = 1'b0;
        data_ack = 1'b0;
        overrun_clear = 1'b0;
        rand_en = 0;
        foreach (line_h[i]) line_h[i] = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) step();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_rx_data", rx_data, 0);
        idle(5, 1);

        // Good character at div 16
        w0 = wr_cnt; e0 = err_cnt; b0 = busy_cnt;
        send_frame(8'hA5, 1, 16, -1, -1);
        idle(10, 1);
        chk("a5_writes", wr_cnt - w0, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_busy_cycles", busy_cnt - b0, 152);
        chk("a5_no_error", err_cnt - e0, 0);
        chk("a5_ready", data_ready, 1);
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
        step();
        chk("a5_ready_acked", data_ready, 0);

        // Framing error, then line held low
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(8'h3C, 0, 16, -1, -1);
        b0 = busy_cnt;
        idle(100, 0);
        chk("ferr_pulses", err_cnt - e0, 1);
        chk("ferr_writes", wr_cnt - w0, 0);
        chk("ferr_keeps_data", rx_data, 8'hA5);
        chk("ferr_low_no_frame", busy_cnt - b0, 0);
        idle(20, 1);

        // Overrun: set, hold across a good frame, set beats clear
        w0 = wr_cnt;
        rcv_full = 1'b1;
        send_frame(8'h55, 1, 16, -1, -1);
        idle(10, 1);
        chk("ovr_set", overrun_error, 1);
        chk("ovr_no_write", wr_cnt - w0, 0);
        rcv_full = 1'b0;
        send_frame(8'h12, 1, 16, -1, -1);
        idle(10, 1);
        chk("ovr_held", overrun_error, 1);
        chk("ovr_next_data", rx_data, 8'h12);
        rcv_full = 1'b1;
        send_frame(8'h77, 1, 16, 2 + 8 + 9 * 16, -1);
        idle(10, 1);
        chk("ovr_set_beats_clear", overrun_error, 1);
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        step();
        chk("ovr_cleared", overrun_error, 0);
        rcv_full = 1'b0;

        // Short low glitch
        w0 = wr_cnt; e0 = err_cnt; b0 = busy_cnt;
        baud_div = 16;
        idle(4, 0);
        idle(40, 1);
        chk("glitch_busy_cycles", busy_cnt - b0, 8);
        chk("glitch_writes", wr_cnt - w0, 0);
        chk("glitch_errors", err_cnt - e0, 0);

        // Reset during data bit 4, then a clean frame
        send_frame(8'hFF, 1, 16, -1, 5 * 16 + 5);
        idle(200, 1);
        w0 = wr_cnt;
        send_frame(8'h81, 1, 16, -1, -1);
        idle(20, 1);
        chk("post_reset_writes", wr_cnt - w0, 1);
        chk("post_reset_data", rx_data, 8'h81);

        // Back-to-back frames at several divisors
        foreach (bds[j]) begin
            bl = (bds[j] < 2) ? 2 : bds[j];
            w0 = wr_cnt;
            send_frame(8'h00, 1, bds[j], -1, -1);
            send_frame(8'hFF, 1, bds[j], -1, -1);
            idle(3 * bl + 10, 1);
            chk("b2b_writes", wr_cnt - w0, 2);
            chk("b2b_first", wq[wq.size()-2], 8'h00);
            chk("b2b_second", wq[wq.size()-1], 8'hFF);
        end

        // Randomized traffic checked cycle-by-cycle against the model
        rand_en = 1;
        repeat (150) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3), 0);
            rcv_full = ($urandom_range(0, 3) == 0);
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0),
                       $urandom_range(0, 10), -1, -1);
            idle($urandom_range(0, 4), 1);
        end
        rand_en = 0;
        rcv_full = 1'b0;
        idle(100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
